// File: rtl/brom_pkg.sv
// rtl/brom_pkg.sv - shared state encoding and address offsets for the boot-ROM line fetcher
package brom_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI,
      RESP,
      DRAIN
   } fetch_state_t;

   localparam int LINE_OFFSET = 4;
   localparam int HALF_OFFSET = 8;

endpackage

// File: rtl/brom_timeout_cnt.sv
// rtl/brom_timeout_cnt.sv - clearable saturating wait counter with terminal-count flag
module brom_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Saturates at the terminal count so a long drain cannot wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/brom_line_fetch.sv
// rtl/brom_line_fetch.sv - splits a 128-bit refill into two 64-bit boot-ROM reads
module brom_line_fetch
   import brom_pkg::*;
#(
   parameter int ADDR_WIDTH     = 24,
   parameter int LINE_WIDTH     = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ic_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
   output logic                  ic_req_ready_o,
   input  logic                  ic_kill_i,
   output logic                  ic_resp_valid_o,
   output logic [LINE_WIDTH-1:0] ic_resp_data_o,
   output logic                  ic_resp_error_o,
   output logic [ADDR_WIDTH-1:0] brom_req_address_o,
   output logic                  brom_req_valid_o,
   input  logic                  brom_ready_i,
   input  logic [127:0]          brom_resp_data_i,
   input  logic                  brom_resp_valid_i
);

   localparam int HALF = LINE_WIDTH / 2;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic                  err_q, err_d;
   logic                  strobe;
   logic                  cnt_clr, cnt_en, cnt_tc;

   logic unused_bits;
   assign unused_bits = ^{ic_req_addr_i[LINE_OFFSET-1:0], brom_resp_data_i[127:HALF]};

   brom_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rstn  (rstn),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      line_d  = line_q;
      err_d   = err_q;
      strobe  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (ic_req_valid_i && !ic_kill_i) begin
               addr_d  = {ic_req_addr_i[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
               line_d  = '0;
               err_d   = 1'b0;
               state_d = REQ_LO;
            end
         end
         // The strobe cycle itself is counted so the timeout is measured from the strobe.
         REQ_LO, REQ_HI: begin
            cnt_clr = 1'b1;
            if (ic_kill_i) begin
               state_d = IDLE;
            end else if (brom_ready_i) begin
               strobe  = 1'b1;
               cnt_clr = 1'b0;
               cnt_en  = 1'b1;
               state_d = (state_q == REQ_LO) ? WAIT_LO : WAIT_HI;
            end
         end
         WAIT_LO: begin
            cnt_en = 1'b1;
            if (brom_resp_valid_i) begin
               line_d[HALF-1:0] = brom_resp_data_i[HALF-1:0];
               addr_d           = addr_q | ADDR_WIDTH'(HALF_OFFSET);
               state_d          = ic_kill_i ? IDLE : REQ_HI;
            end else if (ic_kill_i) begin
               state_d = DRAIN;
            end else if (cnt_tc) begin
               line_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         WAIT_HI: begin
            cnt_en = 1'b1;
            if (brom_resp_valid_i) begin
               line_d[LINE_WIDTH-1:HALF] = brom_resp_data_i[HALF-1:0];
               state_d                   = ic_kill_i ? IDLE : RESP;
            end else if (ic_kill_i) begin
               state_d = DRAIN;
            end else if (cnt_tc) begin
               line_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         DRAIN: begin
            cnt_en = 1'b1;
            if (brom_resp_valid_i || cnt_tc) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         line_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         err_q   <= err_d;
      end
   end

   // Ready is held low while reset is asserted even though the state already reads IDLE.
   assign ic_req_ready_o     = rstn && (state_q == IDLE);
   assign ic_resp_valid_o    = (state_q == RESP);
   assign ic_resp_data_o     = ic_resp_valid_o ? line_q : '0;
   assign ic_resp_error_o    = ic_resp_valid_o && err_q;
   assign brom_req_address_o = addr_q;
   assign brom_req_valid_o   = strobe;

endmodule

// File: tb/tb_brom_line_fetch.sv
// tb/tb_brom_line_fetch.sv - scoreboard bench for brom_line_fetch with a behavioural ROM and line model
module tb_brom_line_fetch;

   logic         clk = 1'b0;
   logic         rstn;
   logic         ic_req_valid_i;
   logic [23:0]  ic_req_addr_i;
   logic         ic_req_ready_o;
   logic         ic_kill_i;
   logic         ic_resp_valid_o;
   logic [127:0] ic_resp_data_o;
   logic         ic_resp_error_o;
   logic [23:0]  brom_req_address_o;
   logic         brom_req_valid_o;
   logic         brom_ready_i = 1'b0;
   logic [127:0] brom_resp_data_i = '0;
   logic         brom_resp_valid_i = 1'b0;

   brom_line_fetch dut (
      .clk                (clk),
      .rstn               (rstn),
      .ic_req_valid_i     (ic_req_valid_i),
      .ic_req_addr_i      (ic_req_addr_i),
      .ic_req_ready_o     (ic_req_ready_o),
      .ic_kill_i          (ic_kill_i),
      .ic_resp_valid_o    (ic_resp_valid_o),
      .ic_resp_data_o     (ic_resp_data_o),
      .ic_resp_error_o    (ic_resp_error_o),
      .brom_req_address_o (brom_req_address_o),
      .brom_req_valid_o   (brom_req_valid_o),
      .brom_ready_i       (brom_ready_i),
      .brom_resp_data_i   (brom_resp_data_i),
      .brom_resp_valid_i  (brom_resp_valid_i)
   );

   always #5 clk = ~clk;

   typedef struct { logic [127:0] data; logic err; int cyc; } exp_t;
   typedef struct { int due; logic [63:0] data; } pend_t;

   exp_t        exp_q[$];
   pend_t       pend_q[$];
   logic [23:0] saddr_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   int last_rom_resp_cyc = -100;
   int last_resp_cyc = -100;
   int last_acc = 0;
   int rom_lat = 5;
   int ready_mode = 1;
   bit rom_mute = 1'b0;
   bit ab_mode = 1'b0;

   function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic void expired(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired before the expected event", nm);
   endfunction

   function automatic logic [63:0] rom_word(input logic [23:0] a);
      if (ab_mode) return a[3] ? 64'hB : 64'hA;
      return {8'hA5, a, 8'h3C, ~a};
   endfunction

   // ROM model: answers rom_lat cycles after each strobe unless muted.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      brom_resp_valid_i = 1'b0;
      brom_resp_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         brom_resp_valid_i      = 1'b1;
         brom_resp_data_i[63:0] = pend_q[0].data;
         void'(pend_q.pop_front());
         last_rom_resp_cyc      = cyc;
      end
      case (ready_mode)
         1:       brom_ready_i = 1'b1;
         2:       brom_ready_i = 1'b0;
         default: brom_ready_i = ($urandom_range(3) != 0);
      endcase
   end

   logic [23:0] sexp;
   always @(negedge clk) begin
      if (brom_req_valid_o) begin
         strobe_cnt++;
         check("strobe_only_when_ready", 128'(brom_ready_i), 128'(1));
         if (saddr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got address %h, expected no strobe", brom_req_address_o);
         end else begin
            sexp = saddr_q.pop_front();
            check("strobe_addr", 128'(brom_req_address_o), 128'(sexp));
         end
         if (!rom_mute) pend_q.push_back(pend_t'{cyc + rom_lat, rom_word(brom_req_address_o)});
      end
   end

   exp_t em;
   always @(negedge clk) begin
      if (ic_resp_valid_o) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: got data %h err %0d, expected no response", ic_resp_data_o, ic_resp_error_o);
         end else begin
            em = exp_q.pop_front();
            check("resp_data", ic_resp_data_o, em.data);
            check("resp_error", 128'(ic_resp_error_o), 128'(em.err));
            if (em.cyc >= 0) check("resp_cycle", 128'(cyc), 128'(em.cyc));
         end
         last_resp_cyc = cyc;
      end
   end

   task automatic issue(input logic [23:0] a, input bit want, input int nstr, input int lat_exp);
      logic [23:0] b;
      exp_t        e;
      bit          ok;
      b = {a[23:4], 4'h0};
      saddr_q.push_back(b);
      if (nstr == 2) saddr_q.push_back(b | 24'h8);
      ic_req_valid_i = 1'b1;
      ic_req_addr_i  = a;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ic_req_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) expired("accept");
      last_acc = cyc;
      if (want) begin
         e.data = rom_mute ? 128'h0 : {rom_word(b | 24'h8), rom_word(b)};
         e.err  = rom_mute;
         e.cyc  = (lat_exp < 0) ? -1 : cyc + lat_exp;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      ic_req_valid_i = 1'b0;
      ic_req_addr_i  = 24'($urandom());
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ic_req_ready_o && exp_q.size() == 0 && saddr_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         expired("idle");
         exp_q.delete();
         saddr_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet();
      check("rst_ready", 128'(ic_req_ready_o), 128'(0));
      check("rst_resp_valid", 128'(ic_resp_valid_o), 128'(0));
      check("rst_resp_data", ic_resp_data_o, 128'(0));
      check("rst_resp_error", 128'(ic_resp_error_o), 128'(0));
      check("rst_brom_valid", 128'(brom_req_valid_o), 128'(0));
      check("rst_brom_addr", 128'(brom_req_address_o), 128'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  s0;
      int  n;
      bit  ok;
      rstn = 1'b0;
      ic_req_valid_i = 1'b0;
      ic_req_addr_i  = '0;
      ic_kill_i      = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet();
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 128'(ic_req_ready_o), 128'(1));
      @(posedge clk); #1;

      // Basic line with 5-cycle ROM: halves A/B, 13-cycle latency.
      ab_mode = 1'b1;
      issue(24'h000105, 1'b1, 2, 13);
      wait_idle(200);
      ab_mode = 1'b0;

      // ROM busy for 7 cycles after accept: no strobe until ready.
      ready_mode = 2;
      s0 = strobe_cnt;
      issue(24'h00A3C4, 1'b1, 2, -1);
      repeat (7) @(negedge clk);
      @(posedge clk); #1;
      check("no_strobe_while_busy", 128'(strobe_cnt - s0), 128'(0));
      ready_mode = 1;
      wait_idle(200);
      check("two_strobes", 128'(strobe_cnt - s0), 128'(2));

      // Kill in WAIT_LO drains the outstanding response.
      rom_lat = 20;
      issue(24'h001230, 1'b0, 1, -1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (brom_req_valid_o) begin ok = 1'b1; break; end
      end
      if (!ok) expired("kill_strobe");
      @(posedge clk); #1;
      ic_kill_i = 1'b1;
      @(posedge clk); #1;
      ic_kill_i = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ic_req_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) expired("kill_ready");
      check("ready_after_drain", 128'(cyc), 128'(last_rom_resp_cyc + 1));
      rom_lat = 5;
      @(posedge clk); #1;
      issue(24'h001240, 1'b1, 2, 13);
      wait_idle(200);

      // ROM never answers: error line exactly 64 cycles after the strobe.
      rom_mute = 1'b1;
      issue(24'h0FFFF8, 1'b1, 1, 65);
      wait_idle(200);
      rom_mute = 1'b0;

      // Back-to-back requests: second accepted the cycle after the first pulse.
      issue(24'h000000, 1'b1, 2, 13);
      issue(24'h000010, 1'b1, 2, 13);
      check("b2b_accept_cycle", 128'(last_acc), 128'(last_resp_cyc + 1));
      wait_idle(200);

      // Reset in WAIT_HI; the stray response must be ignored.
      rom_lat = 10;
      issue(24'h000330, 1'b0, 2, -1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (brom_req_valid_o) n++;
         if (n == 2) break;
      end
      if (n != 2) expired("reset_strobes");
      @(posedge clk); #1;
      rstn = 1'b0;
      @(negedge clk);
      check_quiet();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      check("ready_after_mid_reset", 128'(ic_req_ready_o), 128'(1));
      repeat (15) @(negedge clk);
      check("ready_after_stray", 128'(ic_req_ready_o), 128'(1));
      check("stray_delivered", 128'(pend_q.size()), 128'(0));
      rom_lat = 5;
      @(posedge clk); #1;

      // Randomised traffic with a stalling ROM and occasional timeouts.
      ready_mode = 0;
      for (int k = 0; k < 40; k++) begin
         rom_lat  = $urandom_range(8, 1);
         rom_mute = ($urandom_range(9) == 0);
         issue(24'($urandom()), 1'b1, rom_mute ? 1 : 2, -1);
         wait_idle(400);
         rom_mute = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
